// File: rtl/tt_response_checker_pkg.sv
// Shared types and constants for the truth-table response checker.
// Optional signature register enabled by TT_CHECK_SIGNATURE_EN.
package tt_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // Widest golden table the lookup helper accepts (N_IN <= 8).
    localparam int TBL_MAX_W = 256;

    function automatic logic golden_bit(
        input logic [TBL_MAX_W-1:0] tbl,
        input logic [7:0]           idx
    );
        return tbl[idx];
    endfunction

endpackage

// File: rtl/tt_response_checker_if.sv
// Stimulus/response bundle between vector driver and checker.
// sig exists only when TT_CHECK_SIGNATURE_EN is defined.
interface tt_resp_if #(
    parameter int N_IN  = 4,
    parameter int CNT_W = 5
) ();

    logic             start;
    logic             vec_valid;
    logic [N_IN-1:0]  vec_idx;
    logic             f_obs;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [N_IN-1:0]  first_fail;
    logic             seq_err;
`ifdef TT_CHECK_SIGNATURE_EN
    logic [15:0]      sig;

    modport master (
        output start, vec_valid, vec_idx, f_obs,
        input  busy, done, pass, err_cnt, first_fail, seq_err, sig
    );

    modport slave (
        input  start, vec_valid, vec_idx, f_obs,
        output busy, done, pass, err_cnt, first_fail, seq_err, sig
    );
`else
    modport master (
        output start, vec_valid, vec_idx, f_obs,
        input  busy, done, pass, err_cnt, first_fail, seq_err
    );

    modport slave (
        input  start, vec_valid, vec_idx, f_obs,
        output busy, done, pass, err_cnt, first_fail, seq_err
    );
`endif

endinterface

// File: rtl/tt_response_checker_misr.sv
// 16-bit multiple-input signature register over accepted beats.
// Used only when TT_CHECK_SIGNATURE_EN is defined.
module tt_misr
    import tt_check_pkg::*;
#(
    parameter int DATA_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [15:0]       sig_o
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    // Seed on load, otherwise shift with feedback and fold in the beat.
    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = MISR_SEED;
        end else if (en_i) begin
            sig_d = {sig_q[14:0], 1'b0}
                  ^ (sig_q[15] ? MISR_POLY : 16'h0000)
                  ^ 16'(data_i);
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/tt_response_checker.sv
// Compares an exhaustive truth-table sweep against a golden table.
// Define TT_CHECK_SIGNATURE_EN to add the sig MISR output.
module tt_response_checker
    import tt_check_pkg::*;
#(
    parameter int                    N_IN   = 4,
    parameter logic [(2**N_IN)-1:0]  GOLDEN = 16'h0000,
    parameter int                    CNT_W  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    tt_resp_if.slave    bus
);

    localparam logic [N_IN-1:0]  LAST_IDX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  exp_idx_q, exp_idx_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]  first_fail_q, first_fail_d;
    logic             seq_err_q, seq_err_d;
    logic             pass_q, pass_d;
    logic             mismatch;

    // Golden lookup for the beat currently presented.
    always_comb begin
        mismatch = bus.f_obs
                != golden_bit(TBL_MAX_W'(GOLDEN), 8'(bus.vec_idx));
    end

    // Next-state and result update; start always wins and clears.
    always_comb begin
        state_d      = state_q;
        exp_idx_d    = exp_idx_q;
        err_cnt_d    = err_cnt_q;
        first_fail_d = first_fail_q;
        seq_err_d    = seq_err_q;
        pass_d       = pass_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d      = RUN;
                    exp_idx_d    = '0;
                    err_cnt_d    = '0;
                    first_fail_d = '0;
                    seq_err_d    = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            RUN: begin
                if (bus.start) begin
                    exp_idx_d    = '0;
                    err_cnt_d    = '0;
                    first_fail_d = '0;
                    seq_err_d    = 1'b0;
                    pass_d       = 1'b0;
                end else if (bus.vec_valid) begin
                    exp_idx_d = exp_idx_q + 1'b1;
                    if (mismatch) begin
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (err_cnt_q == '0) begin
                            first_fail_d = bus.vec_idx;
                        end
                    end
                    if (bus.vec_idx != exp_idx_q) begin
                        seq_err_d = 1'b1;
                    end
                    if (exp_idx_q == LAST_IDX) begin
                        state_d = DONE;
                        pass_d  = (err_cnt_d == '0) && !seq_err_d;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            exp_idx_q    <= '0;
            err_cnt_q    <= '0;
            first_fail_q <= '0;
            seq_err_q    <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_idx_q    <= exp_idx_d;
            err_cnt_q    <= err_cnt_d;
            first_fail_q <= first_fail_d;
            seq_err_q    <= seq_err_d;
            pass_q       <= pass_d;
        end
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.first_fail = first_fail_q;
    assign bus.seq_err    = seq_err_q;

`ifdef TT_CHECK_SIGNATURE_EN
    logic beat_acc;

    // A beat counts toward the signature only when it is processed.
    always_comb begin
        beat_acc = (state_q == RUN) && bus.vec_valid && !bus.start;
    end

    tt_misr #(
        .DATA_W (N_IN + 1)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (bus.start),
        .en_i   (beat_acc),
        .data_i ({bus.vec_idx, bus.f_obs}),
        .sig_o  (bus.sig)
    );
`endif

endmodule
